spi_flash_erase_ctrl: RTL and testbench
=======================================

// Module: spi_flash_erase_ctrl
// PURPOSE
//  SPI-master command sequencer for serial NOR flash (M25P16-class).
//  One start pulse runs the full erase sequence:
//   1. WREN.
//   2. Sector erase (SE + 24-bit address) or bulk erase (BE).
//   3. Optional RDSR polling until WIP=0.
//  Sits between user/control logic (key debouncer, UART command decoder) and the flash pins.
// PARAMETERS
//  CLK_DIV    4        sys_clk cycles per SCK period; even, >=2
//  CS_SETUP   8        sys_clk cycles cs_n low before first SCK falling edge
//  CS_HOLD    8        sys_clk cycles after last SCK rising edge before cs_n high
//  CS_GAP     8        min sys_clk cycles cs_n high between commands
//  WREN_INSTR 8'h06    write-enable opcode
//  SE_INSTR   8'hD8    sector-erase opcode
//  BE_INSTR   8'hC7    bulk-erase opcode
//  RDSR_INSTR 8'h05    read-status opcode
//  POLL_EN    1        1: poll status after erase; 0: done right after erase cmd
//  POLL_MAX   16'hFFFF max RDSR transactions before timeout
// PORTS
//  sys_clk  in  1   system clock
//  rst_n    in  1   asynchronous active-low reset
//  start    in  1   1-cycle request; sampled only in IDLE
//  mode     in  1   0 = sector erase, 1 = bulk erase; latched with start
//  addr     in  24  sector address (SE only); latched with start
//  busy     out 1   high from cycle after accepted start until done
//  done     out 1   1-cycle pulse at end of sequence
//  err      out 1   valid with done: 1 = poll timeout
//  cs_n     out 1   flash chip select, active low
//  sck      out 1   SPI clock, SPI mode 3, idles high
//  mosi     out 1   master data out, MSB first
//  miso     in  1   slave data in
// BEHAVIOUR
//  Reset (async, immediate):
//   - cs_n=1, sck=1, mosi=0, busy=0, done=0, err=0; FSM -> IDLE.
//   - Reset mid-transaction aborts it; no further SCK edges.
//  All outputs are registered.
//  FSM: IDLE -> WREN -> GAP -> ERASE -> [GAP -> POLL]* -> FIN -> IDLE.
//  Each command phase is a sub-sequence SETUP -> SHIFT -> HOLD:
//   - SETUP: cs_n=0, count CS_SETUP cycles.
//   - SHIFT: N bits; per bit a CLK_DIV-cycle window, div_cnt 0..CLK_DIV-1.
//       div_cnt==0: sck<=0, mosi<=next bit.
//       div_cnt==CLK_DIV/2: sck<=1; miso sampled on this same edge.
//   - HOLD: count CS_HOLD cycles, then cs_n<=1.
//  Bit counts: WREN 8; SE 32 (opcode, addr[23:0] MSB first); BE 8; RDSR 16.
//  RDSR: 8 opcode bits, then 8 status bits shifted in; mosi=0 during status bits.
//  GAP: cs_n=1, count CS_GAP cycles.
//  POLL completion: status[0] (WIP) == 0 -> FIN with err=0.
//  POLL timeout: WIP==1 after POLL_MAX transactions -> FIN with err=1.
//  POLL_EN=0: FIN follows ERASE HOLD+GAP directly, err=0.
//  FIN: done=1 and busy=0 for exactly one cycle; next cycle IDLE, new start accepted.
//  Bus state: sck stays 1 outside SHIFT; mosi holds last value outside SHIFT.
//  Input handling:
//   - start while busy: ignored, no queueing.
//   - start on the same cycle as done: ignored.
//   - addr and mode are don't-care after acceptance.
//  Counter widths: poll counter 16 bit, saturating at POLL_MAX; other counters sized from parameters.
// TESTING
//  1. CLK_DIV=4, start, mode=0, addr=24'h12_3456; flash model WIP=0 on first RDSR:
//     - 8 SCK pulses 0x06, then 32 pulses D8 12 34 56, then 16-pulse RDSR.
//     - done=1 with err=0; three cs_n low windows.
//  2. mode=1: BE transaction is exactly 8 pulses of 0xC7; no address bits.
//  3. Model holds WIP=1 for 5 polls: exactly 6 RDSR transactions, then done, err=0.
//  4. POLL_MAX=3, WIP stuck at 1: 3 RDSR transactions, then done with err=1.
//  5. Second start mid-ERASE: ignored, sequence unchanged, busy stays 1.
//  6. rst_n low mid-SE-address: cs_n=1, sck=1 same cycle.
//     After release plus a new start, the full sequence restarts cleanly at WREN.

Source files
------------

// File: rtl/spi_flash_erase_ctrl.sv
// SPI mode-3 erase sequencer for serial NOR flash: WREN, then SE/BE, then optional RDSR polling until WIP clears.
// A start pulse is taken only in IDLE and is dropped otherwise; all flash pins and status outputs are registered.
module spi_flash_erase_ctrl #(
  parameter int          CLK_DIV    = 4,
  parameter int          CS_SETUP   = 8,
  parameter int          CS_HOLD    = 8,
  parameter int          CS_GAP     = 8,
  parameter logic [7:0]  WREN_INSTR = 8'h06,
  parameter logic [7:0]  SE_INSTR   = 8'hD8,
  parameter logic [7:0]  BE_INSTR   = 8'hC7,
  parameter logic [7:0]  RDSR_INSTR = 8'h05,
  parameter bit          POLL_EN    = 1'b1,
  parameter logic [15:0] POLL_MAX   = 16'hFFFF
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [23:0] addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_FIN} state_t;
  typedef enum logic [1:0] {CMD_WREN, CMD_ERASE, CMD_POLL} cmd_t;

  localparam int CMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                             : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int CW = $clog2(CMAX + 1);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(CS_GAP - 1);
  // div value on whose closing edge sck rises, and the last div of a bit window
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_t        state, state_nxt;
  cmd_t          cmd, cmd_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] div, div_nxt;
  logic [4:0]    bits, bits_nxt;
  logic [31:0]   sh, sh_nxt;
  logic [7:0]    rx, rx_nxt;
  logic [15:0]   poll_cnt, poll_nxt, poll_inc;
  logic          mode_q, mode_nxt;
  logic [23:0]   addr_q, addr_nxt;
  logic          cs_n_nxt, sck_nxt, mosi_nxt, busy_nxt, done_nxt, err_nxt;
  logic          launch, finish, finish_err;
  cmd_t          launch_cmd;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cmd      <= CMD_WREN;
      cnt      <= '0;
      div      <= '0;
      bits     <= '0;
      sh       <= '0;
      rx       <= '0;
      poll_cnt <= '0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      cs_n     <= 1'b1;
      sck      <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd      <= cmd_nxt;
      cnt      <= cnt_nxt;
      div      <= div_nxt;
      bits     <= bits_nxt;
      sh       <= sh_nxt;
      rx       <= rx_nxt;
      poll_cnt <= poll_nxt;
      mode_q   <= mode_nxt;
      addr_q   <= addr_nxt;
      cs_n     <= cs_n_nxt;
      sck      <= sck_nxt;
      mosi     <= mosi_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_nxt    = cmd;
    cnt_nxt    = cnt;
    div_nxt    = div;
    bits_nxt   = bits;
    sh_nxt     = sh;
    rx_nxt     = rx;
    poll_nxt   = poll_cnt;
    mode_nxt   = mode_q;
    addr_nxt   = addr_q;
    cs_n_nxt   = cs_n;
    sck_nxt    = sck;
    mosi_nxt   = mosi;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    err_nxt    = err;
    launch     = 1'b0;
    launch_cmd = CMD_WREN;
    finish     = 1'b0;
    finish_err = 1'b0;
    poll_inc   = (poll_cnt == POLL_MAX) ? poll_cnt : poll_cnt + 16'd1;

    case (state)
      S_IDLE: begin
        if (start) begin
          launch     = 1'b1;
          launch_cmd = CMD_WREN;
          mode_nxt   = mode;
          addr_nxt   = addr;
          busy_nxt   = 1'b1;
          err_nxt    = 1'b0;
          poll_nxt   = '0;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nxt = S_SHIFT;
          div_nxt   = '0;
          sck_nxt   = 1'b0;
          mosi_nxt  = sh[31];
          sh_nxt    = {sh[30:0], 1'b0};
          case (cmd)
            CMD_WREN:  bits_nxt = 5'd7;
            CMD_ERASE: bits_nxt = mode_q ? 5'd7 : 5'd31;
            default:   bits_nxt = 5'd15;
          endcase
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_SHIFT: begin
        // The last bit leaves on its rising edge so CS_HOLD is measured from that edge.
        if (div == DIV_RISE) begin
          sck_nxt = 1'b1;
          rx_nxt  = {rx[6:0], miso};
          if (bits == '0) begin
            state_nxt = S_HOLD;
            cnt_nxt   = HOLD_LD;
          end else begin
            div_nxt = div + 1'b1;
          end
        end else if (div == DIV_LAST) begin
          div_nxt  = '0;
          sck_nxt  = 1'b0;
          mosi_nxt = sh[31];
          sh_nxt   = {sh[30:0], 1'b0};
          bits_nxt = bits - 5'd1;
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          cs_n_nxt = 1'b1;
          if (cmd == CMD_POLL) begin
            poll_nxt = poll_inc;
            if (!rx[0]) begin
              finish = 1'b1;
            end else if (poll_inc >= POLL_MAX) begin
              finish     = 1'b1;
              finish_err = 1'b1;
            end else begin
              state_nxt = S_GAP;
              cnt_nxt   = GAP_LD;
            end
          end else begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LD;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          if (cmd == CMD_WREN) begin
            launch     = 1'b1;
            launch_cmd = CMD_ERASE;
          end else if (cmd == CMD_ERASE && !POLL_EN) begin
            finish = 1'b1;
          end else begin
            launch     = 1'b1;
            launch_cmd = CMD_POLL;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (launch) begin
      state_nxt = S_SETUP;
      cmd_nxt   = launch_cmd;
      cnt_nxt   = SETUP_LD;
      cs_n_nxt  = 1'b0;
      case (launch_cmd)
        CMD_WREN:  sh_nxt = {WREN_INSTR, 24'h0};
        CMD_ERASE: sh_nxt = mode_nxt ? {BE_INSTR, 24'h0} : {SE_INSTR, addr_nxt};
        default:   sh_nxt = {RDSR_INSTR, 24'h0};
      endcase
    end

    if (finish) begin
      state_nxt = S_FIN;
      done_nxt  = 1'b1;
      busy_nxt  = 1'b0;
      err_nxt   = finish_err;
    end
  end

endmodule

// File: tb/tb_spi_flash_erase_ctrl.sv
// Directed bench for spi_flash_erase_ctrl: a behavioural flash logs every cs_n window and answers RDSR.
// dut0 uses default parameters; dut1 has POLL_MAX=3 for the timeout case.
module tb_spi_flash_erase_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b1;
  logic [1:0]  start_w = '0;
  logic        mode    = 1'b0;
  logic [23:0] addr    = '0;
  logic [1:0]  busy_w, done_w, err_w, cs_w, sck_w, mosi_w;
  logic [1:0]  miso_r  = '0;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  spi_flash_erase_ctrl dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_w[0]), .mode(mode), .addr(addr),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
    .cs_n(cs_w[0]), .sck(sck_w[0]), .mosi(mosi_w[0]), .miso(miso_r[0])
  );

  spi_flash_erase_ctrl #(.POLL_MAX(16'd3)) dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start_w[1]), .mode(mode), .addr(addr),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
    .cs_n(cs_w[1]), .sck(sck_w[1]), .mosi(mosi_w[1]), .miso(miso_r[1])
  );

  // Flash model state, sampled on the falling sys_clk edge
  bit          p_cs  [2] = '{1'b1, 1'b1};
  bit          p_sck [2] = '{1'b1, 1'b1};
  int          m_bits  [2] = '{0, 0};
  int          m_falls [2] = '{0, 0};
  int          m_setup [2] = '{0, 0};
  logic [31:0] m_data  [2] = '{32'h0, 32'h0};
  logic [7:0]  m_stat  [2] = '{8'h0, 8'h0};
  logic [31:0] log_data  [128];
  int          log_bits  [128];
  int          log_setup [128];
  int          log_n     = 0;
  int          poll_seen = 0;
  int          stray     = 0;
  int          wip_polls = 0;
  int          poll_base = 0;

  always @(negedge sys_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs_w[k] == 1'b0) begin
        if (p_cs[k]) begin
          m_bits[k]  = 0;
          m_falls[k] = 0;
          m_setup[k] = 0;
          m_data[k]  = '0;
        end
        if (m_falls[k] == 0 && sck_w[k]) m_setup[k]++;
        if (p_sck[k] && !sck_w[k]) begin
          m_falls[k]++;
          if (m_falls[k] == 9)
            m_stat[k] = 8'h82 | ((m_data[k][7:0] == 8'h05 && (poll_seen - poll_base) < wip_polls) ? 8'h01 : 8'h00);
          if (m_falls[k] >= 9 && m_falls[k] <= 16) miso_r[k] = m_stat[k][16 - m_falls[k]];
        end
        if (!p_sck[k] && sck_w[k]) begin
          m_data[k] = {m_data[k][30:0], mosi_w[k]};
          m_bits[k]++;
        end
      end else begin
        if (!p_cs[k]) begin
          if (log_n < 128) begin
            log_data[log_n]  = m_data[k];
            log_bits[log_n]  = m_bits[k];
            log_setup[log_n] = m_setup[k];
          end
          log_n++;
          if (m_bits[k] == 16 && m_data[k][15:8] == 8'h05) poll_seen++;
        end
        if (p_cs[k] && (p_sck[k] != sck_w[k])) stray++;
      end
      p_cs[k]  = cs_w[k];
      p_sck[k] = sck_w[k];
    end
  end

  task automatic pulse_start(input int k, input logic m, input logic [23:0] a);
    @(negedge sys_clk);
    mode       = m;
    addr       = a;
    start_w[k] = 1'b1;
    @(negedge sys_clk);
    start_w[k] = 1'b0;
    mode       = ~m;
    addr       = ~a;
  endtask

  task automatic wait_done(input int k, input bit start_on_done, output bit ok, output bit e);
    ok = 1'b0;
    e  = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge sys_clk);
      if (done_w[k]) begin
        ok = 1'b1;
        e  = err_w[k];
        if (start_on_done) begin
          start_w[k] = 1'b1;
          @(negedge sys_clk);
          start_w[k] = 1'b0;
        end
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cs_w[k], sck_w[k], mosi_w[k], busy_w[k], done_w[k], err_w[k]} !== 6'b110000) begin
        errors++;
        $display("FAIL reset_state[%0d]: cs,sck,mosi,busy,done,err=%b expected 110000", k,
                 {cs_w[k], sck_w[k], mosi_w[k], busy_w[k], done_w[k], err_w[k]});
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_sector_erase();
    bit ok, e;
    int b, sb;
    wip_polls = 0; poll_base = poll_seen; b = log_n; sb = stray;
    pulse_start(0, 1'b0, 24'h123456);
    checks++;
    if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL se_busy: busy=%b expected 1", busy_w[0]); end
    wait_done(0, 1'b0, ok, e);
    checks++;
    if (!ok) begin errors++; $display("FAIL se_done: done not seen within budget"); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL se_err: err=%b expected 0", e); end
    @(negedge sys_clk);
    checks++;
    if (done_w[0] !== 1'b0) begin errors++; $display("FAIL se_done_width: done=%b expected 0", done_w[0]); end
    checks++;
    if (log_n - b !== 3) begin errors++; $display("FAIL se_windows: got %0d cs_n windows expected 3", log_n - b); end
    checks++;
    if ({log_bits[b], log_bits[b+1], log_bits[b+2]} !== {32'd8, 32'd32, 32'd16}) begin
      errors++;
      $display("FAIL se_bitcounts: got %0d/%0d/%0d expected 8/32/16", log_bits[b], log_bits[b+1], log_bits[b+2]);
    end
    checks++;
    if ({log_data[b], log_data[b+1], log_data[b+2]} !== {32'h06, 32'hD8123456, 32'h0500}) begin
      errors++;
      $display("FAIL se_data: got %h %h %h expected 00000006 d8123456 00000500", log_data[b], log_data[b+1], log_data[b+2]);
    end
    checks++;
    if (log_setup[b] !== 8) begin errors++; $display("FAIL se_cs_setup: got %0d cycles expected 8", log_setup[b]); end
    checks++;
    if (stray !== sb) begin errors++; $display("FAIL se_stray_sck: %0d sck edges with cs_n high expected 0", stray - sb); end
  endtask

  task automatic test_bulk_erase();
    bit ok, e;
    int b;
    wip_polls = 0; poll_base = poll_seen; b = log_n;
    pulse_start(0, 1'b1, 24'hFFFFFF);
    wait_done(0, 1'b0, ok, e);
    @(negedge sys_clk);
    checks++;
    if ({ok, e} !== 2'b10) begin errors++; $display("FAIL be_done_err: done_seen,err=%b expected 10", {ok, e}); end
    checks++;
    if ({log_bits[b], log_bits[b+1], log_bits[b+2]} !== {32'd8, 32'd8, 32'd16}) begin
      errors++;
      $display("FAIL be_bitcounts: got %0d/%0d/%0d expected 8/8/16", log_bits[b], log_bits[b+1], log_bits[b+2]);
    end
    checks++;
    if ({log_data[b], log_data[b+1], log_data[b+2]} !== {32'h06, 32'hC7, 32'h0500}) begin
      errors++;
      $display("FAIL be_data: got %h %h %h expected 00000006 000000c7 00000500", log_data[b], log_data[b+1], log_data[b+2]);
    end
  endtask

  task automatic test_poll_wait();
    bit ok, e;
    int b, n_rdsr;
    wip_polls = 5; poll_base = poll_seen; b = log_n;
    pulse_start(0, 1'b0, 24'h0F0000);
    wait_done(0, 1'b0, ok, e);
    @(negedge sys_clk);
    n_rdsr = 0;
    for (int i = b; i < log_n && i < 128; i++) if (log_data[i] == 32'h0500) n_rdsr++;
    checks++;
    if ({ok, e} !== 2'b10) begin errors++; $display("FAIL poll_done_err: done_seen,err=%b expected 10", {ok, e}); end
    checks++;
    if (n_rdsr !== 6) begin errors++; $display("FAIL poll_rdsr_count: got %0d expected 6", n_rdsr); end
    checks++;
    if (log_n - b !== 8) begin errors++; $display("FAIL poll_windows: got %0d expected 8", log_n - b); end
  endtask

  task automatic test_poll_timeout();
    bit ok, e;
    int b, n_rdsr;
    wip_polls = 100; poll_base = poll_seen; b = log_n;
    pulse_start(1, 1'b0, 24'h000100);
    wait_done(1, 1'b0, ok, e);
    @(negedge sys_clk);
    n_rdsr = 0;
    for (int i = b; i < log_n && i < 128; i++) if (log_data[i] == 32'h0500) n_rdsr++;
    checks++;
    if ({ok, e} !== 2'b11) begin errors++; $display("FAIL timeout_done_err: done_seen,err=%b expected 11", {ok, e}); end
    checks++;
    if (n_rdsr !== 3) begin errors++; $display("FAIL timeout_rdsr_count: got %0d expected 3", n_rdsr); end
    checks++;
    if (log_data[b+1] !== 32'hD8000100) begin errors++; $display("FAIL timeout_se_data: got %h expected d8000100", log_data[b+1]); end
  endtask

  task automatic test_busy_ignore();
    bit ok, e;
    int b;
    wip_polls = 0; poll_base = poll_seen; b = log_n;
    pulse_start(0, 1'b0, 24'h00ABCD);
    for (int c = 0; c < 2000; c++) begin
      @(negedge sys_clk);
      if (log_n - b >= 1 && cs_w[0] == 1'b0) break;
    end
    pulse_start(0, 1'b1, 24'h555555);
    checks++;
    if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL ignore_busy: busy=%b expected 1", busy_w[0]); end
    wait_done(0, 1'b0, ok, e);
    @(negedge sys_clk);
    checks++;
    if (log_n - b !== 3) begin errors++; $display("FAIL ignore_windows: got %0d expected 3", log_n - b); end
    checks++;
    if ({log_data[b], log_data[b+1], log_data[b+2]} !== {32'h06, 32'hD800ABCD, 32'h0500}) begin
      errors++;
      $display("FAIL ignore_data: got %h %h %h expected 00000006 d800abcd 00000500", log_data[b], log_data[b+1], log_data[b+2]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, e;
    int b;
    wip_polls = 0; poll_base = poll_seen; b = log_n;
    pulse_start(0, 1'b0, 24'h0A0000);
    wait_done(0, 1'b1, ok, e);
    checks++;
    if ({ok, busy_w[0]} !== 2'b10) begin errors++; $display("FAIL b2b_start_on_done: done_seen,busy=%b expected 10", {ok, busy_w[0]}); end
    repeat (20) @(negedge sys_clk);
    checks++;
    if (log_n - b !== 3 || cs_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: windows=%0d cs_n=%b expected 3 and 1", log_n - b, cs_w[0]);
    end
    pulse_start(0, 1'b1, 24'h000000);
    wait_done(0, 1'b0, ok, e);
    @(negedge sys_clk);
    checks++;
    if (log_n - b !== 6 || !ok) begin errors++; $display("FAIL b2b_second_run: windows=%0d done_seen=%b expected 6 and 1", log_n - b, ok); end
  endtask

  task automatic test_reset_mid();
    bit ok, e;
    int b, sb;
    wip_polls = 0; poll_base = poll_seen; b = log_n;
    pulse_start(0, 1'b0, 24'h123456);
    for (int c = 0; c < 2000; c++) begin
      @(negedge sys_clk);
      if (log_n - b >= 1 && cs_w[0] == 1'b0 && m_bits[0] >= 12 && sck_w[0] == 1'b0) break;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs_w[0], sck_w[0], busy_w[0]} !== 3'b110) begin
      errors++;
      $display("FAIL rst_mid_pins: cs_n,sck,busy=%b expected 110", {cs_w[0], sck_w[0], busy_w[0]});
    end
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    sb = stray;
    repeat (10) @(negedge sys_clk);
    checks++;
    if (stray !== sb || cs_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_quiet: stray=%0d cs_n=%b expected 0 and 1", stray - sb, cs_w[0]);
    end
    b = log_n;
    pulse_start(0, 1'b0, 24'h123456);
    wait_done(0, 1'b0, ok, e);
    @(negedge sys_clk);
    checks++;
    if ({ok, e} !== 2'b10) begin errors++; $display("FAIL rst_restart_done: done_seen,err=%b expected 10", {ok, e}); end
    checks++;
    if ({log_data[b], log_data[b+1], log_data[b+2]} !== {32'h06, 32'hD8123456, 32'h0500} || log_n - b !== 3) begin
      errors++;
      $display("FAIL rst_restart_data: got %h %h %h (%0d windows) expected 00000006 d8123456 00000500 (3)",
               log_data[b], log_data[b+1], log_data[b+2], log_n - b);
    end
  endtask

  initial begin
    test_reset();
    test_sector_erase();
    test_bulk_erase();
    test_poll_wait();
    test_poll_timeout();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
